// File: rtl/slc3_pkg.sv
// Shared types and constants for the memory/IO access controller.
package slc3_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IO     = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    DONE   = 3'd4
  } mem_state_t;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

  // Wait counter is wide enough for the largest legal wait setting (15).
  localparam int WAIT_W = $clog2(16);

endpackage

// File: rtl/sync2.sv
// Parameterized-width two-flop synchronizer with asynchronous active-low clear.
module sync2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // First flop may go metastable; second flop gives the settled value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_io_ctrl.sv
// Memory/IO access controller: runs SRAM read/write cycles with wait states
// and services the memory-mapped switch/hex-display address.
//
// Handshake: the control unit raises Mem_Req (with Mem_WE, MAR, MDR valid) and
// holds it; the request is taken only in IDLE, where address, direction and
// data are latched. Mem_Ready pulses for exactly one cycle in DONE to mark
// completion; the requester drops Mem_Req on that pulse, otherwise a new access
// starts after the single IDLE cycle that always separates accesses.
module mem_io_ctrl import slc3_pkg::*; #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT,
  parameter int          SRAM_AW     = 20
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Mem_Req,
  input  logic               Mem_WE,
  input  logic [15:0]        MAR,
  input  logic [15:0]        MDR,
  input  logic [15:0]        Switches,
  input  logic [15:0]        SRAM_DQ_in,
  output logic [15:0]        MDR_In,
  output logic               Mem_Ready,
  output logic               Busy,
  output logic [15:0]        HEX_Data,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_DQ_out,
  output logic               SRAM_DQ_oe,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output mem_state_t         state_dbg
);

  mem_state_t        state, next_state;
  logic              we_q, io_q;
  logic [15:0]       mdr_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [15:0]       sw_sync;
  logic              start, next_we, next_io, next_sram, next_drive;

  sync2 #(.W(16)) u_sw_sync (
    .clk   (Clk),
    .rst_n (Reset_n),
    .d     (Switches),
    .q     (sw_sync)
  );

  assign state_dbg = state;

  // Next-state logic plus look-ahead of the attributes of the coming access,
  // so that every strobe can be registered directly from the next state.
  always_comb begin
    next_state = state;
    start      = (state == IDLE) && Mem_Req;
    next_we    = start ? Mem_WE : we_q;
    next_io    = start ? (MAR == IO_ADDR) : io_q;
    unique case (state)
      IDLE:    if (Mem_Req) next_state = (MAR == IO_ADDR) ? IO : SETUP;
      IO:      next_state = DONE;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (wait_cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    next_sram  = (next_state == SETUP) || (next_state == ACCESS);
    // Write data stays on the bus through DONE to give the SRAM hold time.
    next_drive = next_we && !next_io && (next_sram || next_state == DONE);
  end

  // State register, request latches and wait-state counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      io_q     <= 1'b0;
      mdr_q    <= '0;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (start) begin
        we_q  <= Mem_WE;
        io_q  <= (MAR == IO_ADDR);
        mdr_q <= MDR;
      end
      if (state == SETUP)
        wait_cnt <= WAIT_W'(WAIT_CYCLES - 1);
      else if (state == ACCESS && wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // Registered Moore outputs derived from the state being entered.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Mem_Ready   <= 1'b0;
      Busy        <= 1'b0;
      SRAM_ADDR   <= '0;
      SRAM_DQ_out <= '0;
      SRAM_DQ_oe  <= 1'b0;
      SRAM_CE_N   <= 1'b1;
      SRAM_OE_N   <= 1'b1;
      SRAM_WE_N   <= 1'b1;
      SRAM_UB_N   <= 1'b1;
      SRAM_LB_N   <= 1'b1;
    end else begin
      Mem_Ready  <= (next_state == DONE);
      Busy       <= (next_state != IDLE);
      if (start) begin
        SRAM_ADDR   <= {{(SRAM_AW-16){1'b0}}, MAR};
        SRAM_DQ_out <= MDR;
      end
      SRAM_DQ_oe <= next_drive;
      // Chip select also covers DONE of a write so the data hold is honoured.
      SRAM_CE_N  <= !(next_sram || next_drive);
      SRAM_UB_N  <= !(next_sram || next_drive);
      SRAM_LB_N  <= !(next_sram || next_drive);
      SRAM_OE_N  <= !(next_sram && !next_we);
      SRAM_WE_N  <= !(next_state == ACCESS && next_we);
    end
  end

  // Read data capture and hex-display register; both hold between updates.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      MDR_In   <= '0;
      HEX_Data <= '0;
    end else begin
      if (state == IO && !we_q)
        MDR_In <= sw_sync;
      else if (state == ACCESS && wait_cnt == '0 && !we_q)
        MDR_In <= SRAM_DQ_in;
      if (state == IO && we_q)
        HEX_Data <= mdr_q;
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl with WAIT_CYCLES=2. Per-access signal
// activity is captured as bitmasks over cycles 1..8 (bit n = cycle n after the
// edge that samples Mem_Req) and compared against hand-derived masks.
module tb_mem_io_ctrl;
  import slc3_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Mem_Req, Mem_WE;
  logic [15:0] MAR, MDR, Switches, SRAM_DQ_in;
  logic [15:0] MDR_In, HEX_Data, SRAM_DQ_out;
  logic        Mem_Ready, Busy, SRAM_DQ_oe;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
  mem_state_t  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  mem_io_ctrl #(.WAIT_CYCLES(2), .IO_ADDR(16'hFFFF), .SRAM_AW(20)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Mem_Req(Mem_Req), .Mem_WE(Mem_WE),
    .MAR(MAR), .MDR(MDR), .Switches(Switches), .SRAM_DQ_in(SRAM_DQ_in),
    .MDR_In(MDR_In), .Mem_Ready(Mem_Ready), .Busy(Busy), .HEX_Data(HEX_Data),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .state_dbg(state_dbg)
  );

  // Clock
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] mar, mdr, dq_in, sw;
    logic [15:0] exp_mdr_in, exp_hex;
    logic [19:0] exp_addr;
    logic [15:0] m_ready, m_busy, m_oe, m_we, m_ce, m_dqoe;
  } vec_t;

  vec_t vecs[8];

  // Driver: one access, then 8 captured cycles with junk on MAR/MDR/Mem_WE.
  task automatic run_access(input vec_t v,
                            output logic [15:0] r, output logic [15:0] b,
                            output logic [15:0] oe, output logic [15:0] we,
                            output logic [15:0] ce, output logic [15:0] ub,
                            output logic [15:0] lb, output logic [15:0] dqoe,
                            output logic [15:0] clash,
                            output logic [19:0] addr1, output logic [15:0] dqout1);
    r = '0; b = '0; oe = '0; we = '0; ce = '0; ub = '0; lb = '0; dqoe = '0; clash = '0;
    addr1 = '0; dqout1 = '0;
    Switches   = v.sw;
    SRAM_DQ_in = v.dq_in;
    tick(); tick(); tick();
    Mem_Req = 1'b1; Mem_WE = v.we; MAR = v.mar; MDR = v.mdr;
    tick();
    Mem_Req = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      r[i]     = Mem_Ready;
      b[i]     = Busy;
      oe[i]    = !SRAM_OE_N;
      we[i]    = !SRAM_WE_N;
      ce[i]    = !SRAM_CE_N;
      ub[i]    = !SRAM_UB_N;
      lb[i]    = !SRAM_LB_N;
      dqoe[i]  = SRAM_DQ_oe;
      clash[i] = !SRAM_OE_N && SRAM_DQ_oe;
      if (i == 1) begin
        addr1  = SRAM_ADDR;
        dqout1 = SRAM_DQ_out;
      end
      MAR    = 16'($urandom_range(0, 65535));
      MDR    = 16'($urandom_range(0, 65535));
      Mem_WE = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  initial begin
    logic [15:0] r, b, oe, we, ce, ub, lb, dqoe, clash, dqout1;
    logic [19:0] addr1;

    // IO reads: ready cycle 2. SRAM read: strobes cycles 1-3, ready 4.
    // SRAM write: WE_N low 2-3, DQ driven and CE low 1-4, ready 4.
    vecs[0] = '{we:1'b0, mar:16'h0123, mdr:16'h0000, dq_in:16'hBEEF, sw:16'h0000,
                exp_mdr_in:16'hBEEF, exp_hex:16'h0000, exp_addr:20'h00123,
                m_ready:16'h0010, m_busy:16'h001E, m_oe:16'h000E, m_we:16'h0000,
                m_ce:16'h000E, m_dqoe:16'h0000};
    vecs[1] = '{we:1'b1, mar:16'h0040, mdr:16'h1234, dq_in:16'h0000, sw:16'h0000,
                exp_mdr_in:16'hBEEF, exp_hex:16'h0000, exp_addr:20'h00040,
                m_ready:16'h0010, m_busy:16'h001E, m_oe:16'h0000, m_we:16'h000C,
                m_ce:16'h001E, m_dqoe:16'h001E};
    vecs[2] = '{we:1'b0, mar:16'hFFFF, mdr:16'h0000, dq_in:16'h0000, sw:16'h00A5,
                exp_mdr_in:16'h00A5, exp_hex:16'h0000, exp_addr:20'h0FFFF,
                m_ready:16'h0004, m_busy:16'h0006, m_oe:16'h0000, m_we:16'h0000,
                m_ce:16'h0000, m_dqoe:16'h0000};
    vecs[3] = '{we:1'b1, mar:16'hFFFF, mdr:16'h0C3F, dq_in:16'h0000, sw:16'h00A5,
                exp_mdr_in:16'h00A5, exp_hex:16'h0C3F, exp_addr:20'h0FFFF,
                m_ready:16'h0004, m_busy:16'h0006, m_oe:16'h0000, m_we:16'h0000,
                m_ce:16'h0000, m_dqoe:16'h0000};
    vecs[4] = '{we:1'b0, mar:16'hFFFE, mdr:16'h0000, dq_in:16'h5A5A, sw:16'h1111,
                exp_mdr_in:16'h5A5A, exp_hex:16'h0C3F, exp_addr:20'h0FFFE,
                m_ready:16'h0010, m_busy:16'h001E, m_oe:16'h000E, m_we:16'h0000,
                m_ce:16'h000E, m_dqoe:16'h0000};
    vecs[5] = '{we:1'b1, mar:16'h8000, mdr:16'hFFFF, dq_in:16'h3333, sw:16'h1111,
                exp_mdr_in:16'h5A5A, exp_hex:16'h0C3F, exp_addr:20'h08000,
                m_ready:16'h0010, m_busy:16'h001E, m_oe:16'h0000, m_we:16'h000C,
                m_ce:16'h001E, m_dqoe:16'h001E};
    vecs[6] = '{we:1'b0, mar:16'hFFFF, mdr:16'h0000, dq_in:16'h0000, sw:16'hFFFF,
                exp_mdr_in:16'hFFFF, exp_hex:16'h0C3F, exp_addr:20'h0FFFF,
                m_ready:16'h0004, m_busy:16'h0006, m_oe:16'h0000, m_we:16'h0000,
                m_ce:16'h0000, m_dqoe:16'h0000};
    vecs[7] = '{we:1'b0, mar:16'h0000, mdr:16'h0000, dq_in:16'h0001, sw:16'h0000,
                exp_mdr_in:16'h0001, exp_hex:16'h0C3F, exp_addr:20'h00000,
                m_ready:16'h0010, m_busy:16'h001E, m_oe:16'h000E, m_we:16'h0000,
                m_ce:16'h000E, m_dqoe:16'h0000};

    // Reset block
    Reset_n = 1'b0; Mem_Req = 1'b0; Mem_WE = 1'b0; MAR = '0; MDR = '0;
    Switches = '0; SRAM_DQ_in = '0;
    tick(); tick();
    check("rst_mdr_in", MDR_In, 32'h0);
    check("rst_hex", HEX_Data, 32'h0);
    check("rst_ready_busy", {Mem_Ready, Busy}, 32'h0);
    check("rst_addr", SRAM_ADDR, 32'h0);
    check("rst_dq", {SRAM_DQ_oe, SRAM_DQ_out}, 32'h0);
    check("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 32'h1F);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    Reset_n = 1'b1;
    tick();

    // Table-driven accesses
    for (int k = 0; k < 8; k++) begin
      run_access(vecs[k], r, b, oe, we, ce, ub, lb, dqoe, clash, addr1, dqout1);
      check($sformatf("v%0d_ready", k), r, vecs[k].m_ready);
      check($sformatf("v%0d_busy", k), b, vecs[k].m_busy);
      check($sformatf("v%0d_oe", k), oe, vecs[k].m_oe);
      check($sformatf("v%0d_we", k), we, vecs[k].m_we);
      check($sformatf("v%0d_ce", k), ce, vecs[k].m_ce);
      check($sformatf("v%0d_ub", k), ub, vecs[k].m_ce);
      check($sformatf("v%0d_lb", k), lb, vecs[k].m_ce);
      check($sformatf("v%0d_dqoe", k), dqoe, vecs[k].m_dqoe);
      check($sformatf("v%0d_clash", k), clash, 32'h0);
      check($sformatf("v%0d_addr", k), addr1, vecs[k].exp_addr);
      if (vecs[k].we)
        check($sformatf("v%0d_dqout", k), dqout1, vecs[k].mdr);
      check($sformatf("v%0d_mdr_in", k), MDR_In, vecs[k].exp_mdr_in);
      check($sformatf("v%0d_hex", k), HEX_Data, vecs[k].exp_hex);
      check($sformatf("v%0d_state", k), 32'(state_dbg), 32'(IDLE));
    end

    // Mem_Req held high: two reads separated by exactly one IDLE cycle.
    SRAM_DQ_in = 16'h7777;
    Mem_Req = 1'b1; Mem_WE = 1'b0; MAR = 16'h0010; MDR = 16'h0000;
    tick();
    r = '0; b = '0;
    for (int i = 1; i <= 10; i++) begin
      r[i] = Mem_Ready;
      b[i] = Busy;
      if (i == 6) Mem_Req = 1'b0;
      tick();
    end
    check("b2b_busy", b, 32'h03DE);
    check("b2b_ready", r, 32'h0210);
    check("b2b_mdr_in", MDR_In, 32'h7777);

    // Reset asserted in the middle of an SRAM write's ACCESS phase.
    Mem_Req = 1'b1; Mem_WE = 1'b1; MAR = 16'h0200; MDR = 16'hABCD;
    tick();
    Mem_Req = 1'b0;
    tick();
    check("abort_pre_we", SRAM_WE_N, 32'h0);
    #1 Reset_n = 1'b0;
    #1;
    check("abort_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 32'h1F);
    check("abort_dqoe", SRAM_DQ_oe, 32'h0);
    check("abort_ready_busy", {Mem_Ready, Busy}, 32'h0);
    check("abort_state", 32'(state_dbg), 32'(IDLE));
    #1 Reset_n = 1'b1;
    r = '0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      r[i] = Mem_Ready;
    end
    check("abort_no_ready", r, 32'h0);
    check("abort_mdr_in", MDR_In, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
